// File: rtl/bpf_cycle_seq.sv
// BPF instruction-cycle sequencer: FETCH/DECODE/EXEC/WB phase strobes,
// run/halt/step control, fetch-wait timeout and retired-instruction count.
module bpf_cycle_seq #(
  parameter int ICNT_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              step_mode,
  input  logic              step_go,
  input  logic              mem_ack,
  input  logic              exec_busy,
  input  logic              exit_insn,
  output logic              mem_req,
  output logic              ph_fetch,
  output logic              ph_decode,
  output logic              ph_exec,
  output logic              ph_wb,
  output logic              running,
  output logic              halted,
  output logic              timeout_err,
  output logic [ICNT_W-1:0] insn_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_PAUSE,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [7:0] WLIM = 8'(WAIT_MAX);

  state_t            state;
  state_t            state_nx;
  logic [7:0]        wcnt;
  logic [7:0]        wcnt_nx;
  logic              hlatch;
  logic              hlatch_nx;
  logic [ICNT_W-1:0] cnt_nx;
  logic              run_st;

  assign run_st = (state == S_FETCH) || (state == S_DECODE) ||
                  (state == S_EXEC)  || (state == S_WB) ||
                  (state == S_PAUSE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      hlatch   <= 1'b0;
      insn_cnt <= '0;
    end else begin
      state    <= state_nx;
      wcnt     <= wcnt_nx;
      hlatch   <= hlatch_nx;
      insn_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wcnt_nx   = '0;
    hlatch_nx = hlatch;
    cnt_nx    = insn_cnt;
    unique case (state)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          state_nx = S_FETCH;
          cnt_nx   = '0;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_nx = S_DECODE;
        end else begin
          wcnt_nx = wcnt + 8'd1;
          if (wcnt_nx == WLIM) state_nx = S_ERR;
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (!exec_busy) state_nx = S_WB;
      end
      S_WB: begin
        cnt_nx = insn_cnt + 1'b1;
        if (exit_insn || hlatch || halt_req) state_nx = S_HALT;
        else if (step_mode)                  state_nx = S_PAUSE;
        else                                 state_nx = S_FETCH;
      end
      S_PAUSE: begin
        if (halt_req)                   state_nx = S_HALT;
        else if (step_go || !step_mode) state_nx = S_FETCH;
      end
    endcase
    if (run_st && halt_req) hlatch_nx = 1'b1;
    // the pending stop is consumed by whichever path enters HALT
    if (state_nx == S_HALT) hlatch_nx = 1'b0;
  end

  assign mem_req     = (state == S_FETCH);
  assign ph_fetch    = (state == S_FETCH);
  assign ph_decode   = (state == S_DECODE);
  assign ph_exec     = (state == S_EXEC);
  assign ph_wb       = (state == S_WB);
  assign running     = run_st;
  assign halted      = (state == S_HALT);
  assign timeout_err = (state == S_ERR);

endmodule

// File: tb/tb_bpf_cycle_seq.sv
// Bench for bpf_cycle_seq: directed scenarios plus a random run
// compared cycle by cycle against a behavioural model.
module tb_bpf_cycle_seq;

  localparam int ICNT_W   = 32;
  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic halt_req = 1'b0;
  logic step_mode = 1'b0;
  logic step_go = 1'b0;
  logic mem_ack = 1'b0;
  logic exec_busy = 1'b0;
  logic exit_insn = 1'b0;
  logic mem_req, ph_fetch, ph_decode, ph_exec, ph_wb;
  logic running, halted, timeout_err;
  logic [ICNT_W-1:0] insn_cnt;
  logic [7:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bpf_cycle_seq #(.ICNT_W(ICNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .step_mode(step_mode), .step_go(step_go), .mem_ack(mem_ack),
    .exec_busy(exec_busy), .exit_insn(exit_insn), .mem_req(mem_req),
    .ph_fetch(ph_fetch), .ph_decode(ph_decode), .ph_exec(ph_exec),
    .ph_wb(ph_wb), .running(running), .halted(halted),
    .timeout_err(timeout_err), .insn_cnt(insn_cnt)
  );

  assign obs = {mem_req, ph_fetch, ph_decode, ph_exec, ph_wb,
                running, halted, timeout_err};

  typedef enum {M_IDLE, M_F, M_D, M_E, M_W, M_P, M_H, M_ERR} mph_t;
  mph_t m_ph;
  int m_wait;
  bit m_stop;
  logic [ICNT_W-1:0] m_cnt;

  // {mem_req, fetch, decode, exec, wb, running, halted, timeout_err}
  function automatic logic [7:0] m_out();
    logic [7:0] o;
    o = 8'h00;
    case (m_ph)
      M_F:   o = 8'b1100_0100;
      M_D:   o = 8'b0010_0100;
      M_E:   o = 8'b0001_0100;
      M_W:   o = 8'b0000_1100;
      M_P:   o = 8'b0000_0100;
      M_H:   o = 8'b0000_0010;
      M_ERR: o = 8'b0000_0001;
      default: o = 8'h00;
    endcase
    return o;
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE;
    m_wait = 0;
    m_stop = 0;
    m_cnt = '0;
  endtask

  task automatic model_step();
    mph_t nx;
    nx = m_ph;
    if (m_ph inside {M_F, M_D, M_E, M_W, M_P} && halt_req) m_stop = 1;
    case (m_ph)
      M_IDLE, M_H, M_ERR:
        if (start) begin nx = M_F; m_cnt = '0; m_wait = 0; end
      M_F:
        if (mem_ack) begin nx = M_D; m_wait = 0; end
        else begin
          m_wait++;
          if (m_wait == WAIT_MAX) nx = M_ERR;
        end
      M_D: nx = M_E;
      M_E: if (!exec_busy) nx = M_W;
      M_W: begin
        m_cnt = m_cnt + 1;
        if (exit_insn || m_stop) nx = M_H;
        else if (step_mode) nx = M_P;
        else nx = M_F;
      end
      M_P:
        if (halt_req) nx = M_H;
        else if (step_go || !step_mode) nx = M_F;
      default: nx = M_IDLE;
    endcase
    if (nx == M_H) m_stop = 0;
    m_ph = nx;
  endtask

  task automatic tick();
    if (!rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({obs, insn_cnt} !== 40'h0) begin
      failures++;
      $display("FAIL rst_async got=%0h exp=0", {obs, insn_cnt});
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL rst_hold got=%0h exp=0", obs);
    end
    rst = 1'b1;
    model_reset();
    tick();
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL rst_idle got=%0h exp=0", obs);
    end
  endtask

  task automatic wait_halt(input string nm);
    for (int k = 0; k < 60 && !halted; k++) tick();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL %s_halt_wait got=%b exp=1", nm, halted);
    end
    halt_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    mem_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp = 4'b1000 >> (i % 4);
      checks++;
      if ({ph_fetch, ph_decode, ph_exec, ph_wb} !== exp) begin
        failures++;
        $display("FAIL b2b_phase[%0d] got=%b exp=%b", i,
                 {ph_fetch, ph_decode, ph_exec, ph_wb}, exp);
      end
      tick();
    end
    checks++;
    if (insn_cnt !== 32'd5) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d exp=5", insn_cnt);
    end
    halt_req = 1'b1;
    wait_halt("b2b");
  endtask

  task automatic test_wait_exec();
    logic [3:0] exp;
    mem_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      mem_ack = (c == 3);
      exec_busy = (c == 5 || c == 6);
      exp = (c < 4) ? 4'b1000 : (c == 4) ? 4'b0100 :
            (c < 8) ? 4'b0010 : 4'b0001;
      checks++;
      if ({ph_fetch, ph_decode, ph_exec, ph_wb, mem_req} !== {exp, exp[3]})
      begin
        failures++;
        $display("FAIL wait_phase[%0d] got=%b exp=%b", c,
                 {ph_fetch, ph_decode, ph_exec, ph_wb, mem_req},
                 {exp, exp[3]});
      end
      tick();
    end
    checks++;
    if ({ph_fetch, insn_cnt} !== {1'b1, 32'd1}) begin
      failures++;
      $display("FAIL wait_period got=%b/%0d exp=1/1", ph_fetch, insn_cnt);
    end
    exec_busy = 1'b0;
    mem_ack = 1'b1;
    halt_req = 1'b1;
    wait_halt("wait");
  endtask

  task automatic test_timeout();
    mem_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mem_ack = 1'b0;
    repeat (3) tick();
    for (int k = 1; k <= WAIT_MAX; k++) begin
      checks++;
      if ({mem_req, ph_fetch, timeout_err} !== 3'b110) begin
        failures++;
        $display("FAIL to_fetch[%0d] got=%b exp=110", k,
                 {mem_req, ph_fetch, timeout_err});
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({obs, insn_cnt} !== {8'b0000_0001, 32'd1}) begin
        failures++;
        $display("FAIL to_err[%0d] got=%0h exp=%0h", k, {obs, insn_cnt},
                 {8'b0000_0001, 32'd1});
      end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({ph_fetch, timeout_err, insn_cnt} !== {2'b10, 32'd0}) begin
      failures++;
      $display("FAIL to_restart got=%b/%b/%0d exp=1/0/0", ph_fetch,
               timeout_err, insn_cnt);
    end
    repeat (WAIT_MAX - 1) tick();
    mem_ack = 1'b1;
    tick();
    checks++;
    if ({ph_decode, timeout_err} !== 2'b10) begin
      failures++;
      $display("FAIL to_ack_wins got=%b exp=10", {ph_decode, timeout_err});
    end
    halt_req = 1'b1;
    wait_halt("to");
  endtask

  task automatic test_step();
    mem_ack = 1'b1;
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (insn_cnt !== 32'd1) begin
      failures++;
      $display("FAIL step_cnt1 got=%0d exp=1", insn_cnt);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (obs !== 8'b0000_0100) begin
        failures++;
        $display("FAIL step_pause[%0d] got=%b exp=00000100", k, obs);
      end
      tick();
    end
    step_go = 1'b1;
    tick();
    step_go = 1'b0;
    checks++;
    if (ph_fetch !== 1'b1) begin
      failures++;
      $display("FAIL step_go got=%b exp=1", ph_fetch);
    end
    repeat (4) tick();
    checks++;
    if ({obs, insn_cnt} !== {8'b0000_0100, 32'd2}) begin
      failures++;
      $display("FAIL step_cnt2 got=%b/%0d exp=00000100/2", obs, insn_cnt);
    end
    step_mode = 1'b0;
    tick();
    checks++;
    if (ph_fetch !== 1'b1) begin
      failures++;
      $display("FAIL step_release got=%b exp=1", ph_fetch);
    end
    halt_req = 1'b1;
    wait_halt("step");
  endtask

  task automatic test_halt_req();
    mem_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    checks++;
    if (ph_decode !== 1'b1) begin
      failures++;
      $display("FAIL hreq_decode got=%b exp=1", ph_decode);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    checks++;
    if (ph_wb !== 1'b1) begin
      failures++;
      $display("FAIL hreq_wb got=%b exp=1", ph_wb);
    end
    tick();
    checks++;
    if ({halted, running, insn_cnt} !== {2'b10, 32'd3}) begin
      failures++;
      $display("FAIL hreq_halt got=%b%b/%0d exp=10/3", halted, running,
               insn_cnt);
    end
  endtask

  task automatic test_exit_priority();
    mem_ack = 1'b1;
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    exit_insn = 1'b1;
    tick();
    exit_insn = 1'b0;
    checks++;
    if ({obs, insn_cnt} !== {8'b0000_0010, 32'd1}) begin
      failures++;
      $display("FAIL exit_vs_pause got=%b/%0d exp=00000010/1", obs, insn_cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    halt_req = 1'b1;
    step_go = 1'b1;
    tick();
    halt_req = 1'b0;
    step_go = 1'b0;
    checks++;
    if (obs !== 8'b0000_0010) begin
      failures++;
      $display("FAIL pause_halt_vs_go got=%b exp=00000010", obs);
    end
    step_mode = 1'b0;
  endtask

  task automatic test_reset_midexec();
    mem_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    exec_busy = 1'b1;
    tick();
    checks++;
    if ({ph_exec, insn_cnt} !== {1'b1, 32'd1}) begin
      failures++;
      $display("FAIL mid_exec got=%b/%0d exp=1/1", ph_exec, insn_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({obs, insn_cnt} !== 40'h0) begin
      failures++;
      $display("FAIL mid_rst got=%0h exp=0", {obs, insn_cnt});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exec_busy = 1'b0;
    tick();
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst_idle got=%b exp=0", obs);
    end
  endtask

  task automatic test_random();
    bit stall;
    stall = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) stall = ($urandom_range(0, 3) == 0);
      start     = ($urandom_range(0, 5) == 0);
      halt_req  = ($urandom_range(0, 15) == 0);
      step_go   = ($urandom_range(0, 3) == 0);
      exec_busy = ($urandom_range(0, 1) == 1);
      exit_insn = ($urandom_range(0, 15) == 0);
      mem_ack   = stall ? ($urandom_range(0, 31) == 0)
                        : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) step_mode = ~step_mode;
      tick();
      checks++;
      if ({obs, insn_cnt} !== {m_out(), m_cnt}) begin
        failures++;
        $display("FAIL rand[%0d] got=%b/%0d exp=%b/%0d", n, obs, insn_cnt,
                 m_out(), m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_wait_exec();
    test_timeout();
    test_step();
    test_halt_req();
    test_exit_priority();
    test_reset_midexec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpf_cycle_seq.md
Name: bpf_cycle_seq

Overview:
- Instruction-cycle sequencer for the BPF core; replaces free-running 4-step phase generation with a controlled FETCH/DECODE/EXEC/WB sequence.
- Adds run/halt control, single-step debug, a memory-wait handshake with timeout, a variable-length execute phase and a retired-instruction counter.
- Sits between the top-level control/debug interface and the fetch unit, decoder, ALU and register file. All four consume its one-hot phase strobes.

Parameters:
- ICNT_W, 32: width of the retired-instruction counter.
- WAIT_MAX, 15: maximum FETCH cycles spent waiting for mem_ack before the error state. Range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin execution; level, sampled each cycle.
- halt_req  input  1  request a stop at the next instruction boundary.
- step_mode  input  1  1 = pause after every instruction.
- step_go  input  1  in PAUSE, releases exactly one instruction.
- mem_ack  input  1  instruction memory has returned data.
- exec_busy  input  1  ALU needs more cycles; holds EXEC.
- exit_insn  input  1  decoder flags BPF_EXIT; valid during WB.
- mem_req  output  1  instruction fetch request.
- ph_fetch  output  1  phase strobe.
- ph_decode  output  1  phase strobe.
- ph_exec  output  1  phase strobe.
- ph_wb  output  1  phase strobe.
- running  output  1  high in FETCH, DECODE, EXEC, WB and PAUSE.
- halted  output  1  high in HALT.
- timeout_err  output  1  high in ERR.
- insn_cnt  output  ICNT_W  number of retired instructions.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all outputs 0, insn_cnt=0, wait counter=0, halt latch=0. Leaving reset is synchronous to the first clock edge.
- Output decode: all outputs are decoded from registered state only (Moore). No combinational input-to-output path. At most one ph_* is high in any cycle; all are low in IDLE, PAUSE, HALT and ERR.
- IDLE: start=1 -> FETCH on the next edge, and insn_cnt is cleared to 0.
- FETCH: ph_fetch=1, mem_req=1.
  - mem_ack=1 -> DECODE; wait counter is reset to 0.
  - Otherwise the wait counter increments. When the counter reaches WAIT_MAX with no ack -> ERR.
  - mem_ack in the same cycle the counter reaches WAIT_MAX: the ack wins (-> DECODE).
- DECODE: exactly 1 cycle, ph_decode=1 -> EXEC.
- EXEC: ph_exec=1.
  - Stays in EXEC while exec_busy=1; exec_busy=0 -> WB.
  - Minimum EXEC length is 1 cycle. No upper bound.
- WB: exactly 1 cycle, ph_wb=1. insn_cnt increments by 1 with wrap-around at 2^ICNT_W. Next state, highest priority first:
  - exit_insn=1 -> HALT.
  - halt latch set, or halt_req=1 this cycle -> HALT. The latch is cleared on entry.
  - step_mode=1 -> PAUSE.
  - otherwise -> FETCH.
- Minimum instruction period: 4 cycles (1 cycle each of FETCH, DECODE, EXEC, WB).
- halt_req latch: set by halt_req=1 in any running state; consumed only at WB. An in-flight instruction always completes. halt_req in IDLE, HALT or ERR is ignored.
- PAUSE:
  - step_go=1 -> FETCH.
  - halt_req=1 -> HALT, with priority over step_go.
  - step_mode dropping to 0 while in PAUSE -> FETCH.
- HALT: halted=1. start=1 -> FETCH and clears insn_cnt.
- ERR: timeout_err=1, sticky. Only start=1 (-> FETCH, clears insn_cnt and the error) or reset leaves ERR.
- start while running is ignored.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. No partial WB or counter increment.

Test Plan:
- Reset, then start pulse with mem_ack tied 1 and exec_busy=0:
  - phases repeat fetch, decode, exec, wb every 4 cycles;
  - insn_cnt=5 after 20 cycles from FETCH entry.
- mem_ack delayed 3 cycles, exec_busy high for 2 cycles:
  - instruction period is 9 cycles;
  - mem_req stays high for all 4 FETCH cycles.
- Hold mem_ack=0 with WAIT_MAX=15:
  - ERR entered after 15 FETCH cycles, timeout_err=1;
  - a later start returns to FETCH with timeout_err=0 and insn_cnt=0.
- step_mode=1:
  - after one instruction the sequencer sits in PAUSE (running=1, all ph_*=0) for 10 cycles;
  - a step_go pulse executes exactly one more instruction; insn_cnt goes from 1 to 2.
- halt_req pulsed during DECODE of instruction 3:
  - WB of instruction 3 completes, then HALT;
  - halted=1, insn_cnt=3.
- exit_insn=1 in WB together with step_mode=1: HALT wins over PAUSE.
- rst asserted during EXEC: all outputs 0 immediately, with no clock edge required.
